sbox_table_loader: RTL

SBOX_TABLE_LOADER -- requirements
Module: sbox_table_loader

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/sbox_lut.sv | 26 ++
 rtl/sbox_table_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the S-box table loader: FSM encoding, table size,
// mode encodings and GF(2^8) helpers used to generate table contents.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam int         TABLE_SIZE = 256;
  localparam logic [7:0] ADDR_LAST  = 8'(TABLE_SIZE - 1);

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h01;
    pw  = x;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      acc = gf_mul(acc, pw);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

endpackage

// File: rtl/sbox_lut.sv
// Combinational AES S-box lookup; mode selects forward or inverse table.
module sbox_lut
  import aes_pkg::*;
(
  input  logic       mode,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  logic [7:0] fwd_val;
  logic [7:0] inv_pre;
  logic [7:0] inv_val;
  logic [7:0] fwd_inv;

  // Forward: affine transform of the field inverse.
  assign fwd_inv = gf_inv(addr);
  assign fwd_val = fwd_inv ^ rotl8(fwd_inv, 1) ^ rotl8(fwd_inv, 2)
                 ^ rotl8(fwd_inv, 3) ^ rotl8(fwd_inv, 4) ^ 8'h63;

  // Inverse: undo the affine transform, then take the field inverse.
  assign inv_pre = rotl8(addr, 1) ^ rotl8(addr, 3) ^ rotl8(addr, 6) ^ 8'h05;
  assign inv_val = gf_inv(inv_pre);

  assign data = (mode == MODE_INV) ? inv_val : fwd_val;

endmodule

// File: rtl/sbox_table_loader.sv
// Loads AES forward/inverse S-box tables into up to 16 RAM banks and
// optionally reads them back to verify contents.
//
// state  | meaning
// IDLE   | waiting for start (or the one-shot auto-load after reset)
// WRITE  | streaming addresses 0..255 with table data to masked banks
// VERIFY | reading 0..255 back, comparing masked banks after RD_LATENCY
// DONE   | tables loaded (and verified); ram_ready high
// FAIL   | read-back mismatch; error and err_addr hold the first failure
module sbox_table_loader
  import aes_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int RD_LATENCY = 1,
  parameter int VERIFY_EN  = 1,
  parameter int AUTO_LOAD  = 1,
  parameter int AUTO_MODE  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [NUM_BANKS-1:0]   bank_mask,
  output logic [NUM_BANKS-1:0]   wr_enable,
  output logic [7:0]             wr_addr,
  output logic [7:0]             wr_data,
  output logic                   rd_enable,
  output logic [7:0]             rd_addr,
  input  logic [8*NUM_BANKS-1:0] rd_data,
  output logic                   busy,
  output logic                   ram_ready,
  output logic                   error,
  output logic [7:0]             err_addr
);

  localparam logic AUTO_MODE_SEL = (AUTO_MODE != 0) ? MODE_INV : MODE_FWD;

  state_t                 state;
  logic                   mode_q;
  logic [NUM_BANKS-1:0]   mask_q;
  logic                   auto_pend;

  logic [RD_LATENCY-1:0]      dly_valid;
  logic [RD_LATENCY-1:0][7:0] dly_addr;

  logic                 accept;
  logic                 acc_mode;
  logic [NUM_BANKS-1:0] acc_mask;
  logic                 cmp_valid;
  logic [7:0]           cmp_addr;
  logic [7:0]           cmp_exp;
  logic                 mismatch;

  sbox_lut u_wr_lut (
    .mode (mode_q),
    .addr (wr_addr),
    .data (wr_data)
  );

  sbox_lut u_cmp_lut (
    .mode (mode_q),
    .addr (cmp_addr),
    .data (cmp_exp)
  );

  // The auto-load takes priority over a user start in the first cycle.
  always_comb begin
    accept   = 1'b0;
    acc_mode = mode;
    acc_mask = bank_mask;
    if (state == ST_IDLE || state == ST_DONE || state == ST_FAIL) begin
      if (auto_pend && state == ST_IDLE) begin
        accept   = 1'b1;
        acc_mode = AUTO_MODE_SEL;
        acc_mask = '1;
      end else if (start && (bank_mask != '0)) begin
        accept = 1'b1;
      end
    end
  end

  assign cmp_valid = dly_valid[RD_LATENCY-1] && (state == ST_VERIFY);
  assign cmp_addr  = dly_addr[RD_LATENCY-1];

  always_comb begin
    mismatch = 1'b0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (mask_q[k] && (rd_data[8*k +: 8] != cmp_exp)) mismatch = 1'b1;
    end
  end

  // Address/valid delay line aligning each read with its returned data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dly_valid <= '0;
      dly_addr  <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        dly_valid[i] <= dly_valid[i-1];
        dly_addr[i]  <= dly_addr[i-1];
      end
      dly_valid[0] <= rd_enable;
      dly_addr[0]  <= rd_addr;
      if (cmp_valid && mismatch) dly_valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_FWD;
      mask_q    <= '0;
      auto_pend <= (AUTO_LOAD != 0);
      wr_enable <= '0;
      wr_addr   <= 8'h00;
      rd_enable <= 1'b0;
      rd_addr   <= 8'h00;
      busy      <= 1'b0;
      ram_ready <= 1'b0;
      error     <= 1'b0;
      err_addr  <= 8'h00;
    end else begin
      auto_pend <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (accept) begin
            state     <= ST_WRITE;
            mode_q    <= acc_mode;
            mask_q    <= acc_mask;
            wr_enable <= acc_mask;
            wr_addr   <= 8'h00;
            rd_addr   <= 8'h00;
            busy      <= 1'b1;
            ram_ready <= 1'b0;
            error     <= 1'b0;
            err_addr  <= 8'h00;
          end
        end
        ST_WRITE: begin
          if (wr_addr == ADDR_LAST) begin
            wr_enable <= '0;
            if (VERIFY_EN != 0) begin
              state     <= ST_VERIFY;
              rd_enable <= 1'b1;
              rd_addr   <= 8'h00;
            end else begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              ram_ready <= 1'b1;
            end
          end else begin
            wr_addr <= wr_addr + 8'd1;
          end
        end
        ST_VERIFY: begin
          if (rd_enable) begin
            if (rd_addr == ADDR_LAST) rd_enable <= 1'b0;
            else                      rd_addr   <= rd_addr + 8'd1;
          end
          // Reads still in flight are abandoned on the first mismatch.
          if (cmp_valid && mismatch) begin
            state     <= ST_FAIL;
            rd_enable <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            err_addr  <= cmp_addr;
          end else if (cmp_valid && cmp_addr == ADDR_LAST) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            ram_ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
